// File: rtl/rt_var_delay_mc.sv
// Multi-channel runtime-variable delay line: per-channel circular buffers sharing
// one write pointer, each channel with its own loadable, clamped delay and fill tracking.
module rt_var_delay_mc #(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 3,
  parameter int DELAY_W    = 4,
  parameter int INIT_DELAY = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NUM_CH-1:0]          delay_ld,
  input  logic [NUM_CH*DELAY_W-1:0]  delay,
  input  logic [NUM_CH*DATA_W-1:0]   in,
  output logic [NUM_CH*DATA_W-1:0]   out,
  output logic [NUM_CH-1:0]          out_valid,
  output logic [NUM_CH-1:0]          delay_err
);

  localparam int MAXD   = 1 << ADDR_W;
  localparam int INIT_C = (INIT_DELAY < 1) ? 1 : ((INIT_DELAY > MAXD) ? MAXD : INIT_DELAY);
  localparam logic [DELAY_W-1:0] MAXD_D = DELAY_W'(MAXD);
  localparam logic [DELAY_W-1:0] INIT_D = DELAY_W'(INIT_C);
  localparam logic [DELAY_W-1:0] ONE_D  = DELAY_W'(1);

  logic [ADDR_W-1:0] wp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
    end else if (en) begin
      wp <= wp + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DATA_W-1:0]  mem [MAXD];
    logic [DATA_W-1:0]  din;
    logic [DATA_W-1:0]  rd_data;
    logic [DATA_W-1:0]  q;
    logic [DELAY_W-1:0] d_req;
    logic [DELAY_W-1:0] d_clamp;
    logic [DELAY_W-1:0] cur_d;
    logic [DELAY_W-1:0] fill;
    logic [DELAY_W-1:0] fill_nx;
    logic [ADDR_W-1:0]  rd_addr;
    logic               bad;
    logic               vld;
    logic               err;

    always_comb begin
      din     = in[g*DATA_W +: DATA_W];
      d_req   = delay[g*DELAY_W +: DELAY_W];
      bad     = (d_req == '0) || (d_req > MAXD_D);
      d_clamp = d_req;
      if (d_req == '0) begin
        d_clamp = ONE_D;
      end else if (d_req > MAXD_D) begin
        d_clamp = MAXD_D;
      end
      // Read is taken before this edge's write; cur_d-1 <= MAXD-1 never aliases wp.
      rd_addr = wp - ADDR_W'(cur_d - ONE_D);
      rd_data = mem[rd_addr];
      fill_nx = fill + ONE_D;
    end

    always_ff @(posedge clk) begin
      if (en) begin
        mem[wp] <= din;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cur_d <= INIT_D;
        fill  <= '0;
        q     <= '0;
        vld   <= 1'b0;
        err   <= 1'b0;
      end else if (delay_ld[g]) begin
        cur_d <= d_clamp;
        fill  <= '0;
        vld   <= 1'b0;
        err   <= bad;
      end else if (en) begin
        fill <= (fill_nx >= cur_d) ? cur_d : fill_nx;
        vld  <= (fill_nx >= cur_d);
        q    <= (cur_d == ONE_D) ? din : rd_data;
      end
    end

    assign out[g*DATA_W +: DATA_W] = q;
    assign out_valid[g]            = vld;
    assign delay_err[g]            = err;
  end

endmodule

// File: tb/tb_rt_var_delay_mc.sv
// Bench for rt_var_delay_mc: constant vector table, hand-built corner sequences and
// randomized traffic checked against a history-queue reference model.
module tb_rt_var_delay_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  delay_ld;
  logic [7:0]  delay;
  logic [15:0] din;
  logic [15:0] dout;
  logic [1:0]  out_valid;
  logic [1:0]  delay_err;

  int total = 0;
  int bad   = 0;

  rt_var_delay_mc #(
    .DATA_W(8), .NUM_CH(2), .ADDR_W(3), .DELAY_W(4), .INIT_DELAY(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .delay_ld(delay_ld), .delay(delay),
    .in(din), .out(dout), .out_valid(out_valid), .delay_err(delay_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: every accepted sample pair is kept in a history queue;
  // an output equals the sample accepted (delay-1) enable edges earlier.
  logic [15:0] hist[$];
  int          m_d[2];
  int          m_fill[2];
  bit          m_val[2];
  bit          m_err[2];
  bit          m_known[2];
  logic [7:0]  m_out[2];

  function automatic int clampd(input int d);
    if (d == 0) return 1;
    if (d > 8) return 8;
    return d;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int c = 0; c < 2; c++) begin
      m_d[c] = 3; m_fill[c] = 0; m_val[c] = 0; m_err[c] = 0;
      m_known[c] = 1; m_out[c] = 8'h00;
    end
  endtask

  task automatic model_step(input bit e, input logic [1:0] l, input logic [7:0] dl,
                            input logic [15:0] x);
    for (int c = 0; c < 2; c++) begin
      int d;
      logic [7:0] xi;
      d  = (c == 0) ? int'(dl[3:0]) : int'(dl[7:4]);
      xi = (c == 0) ? x[7:0] : x[15:8];
      if (l[c]) begin
        m_d[c] = clampd(d); m_fill[c] = 0; m_val[c] = 0;
        m_err[c] = (d == 0) || (d > 8);
      end else if (e) begin
        if (m_d[c] == 1) begin
          m_out[c] = xi; m_known[c] = 1;
        end else if (hist.size() >= m_d[c] - 1) begin
          logic [15:0] h;
          h = hist[hist.size() - (m_d[c] - 1)];
          m_out[c] = (c == 0) ? h[7:0] : h[15:8];
          m_known[c] = 1;
        end else begin
          m_known[c] = 0;
        end
        m_val[c]  = (m_fill[c] + 1 >= m_d[c]);
        m_fill[c] = (m_fill[c] + 1 > m_d[c]) ? m_d[c] : m_fill[c] + 1;
      end
    end
    if (e) hist.push_back(x);
  endtask

  task automatic model_check();
    for (int c = 0; c < 2; c++) begin
      logic [7:0] o;
      o = (c == 0) ? dout[7:0] : dout[15:8];
      if (m_known[c]) chk($sformatf("model_out%0d", c), 32'(o), 32'(m_out[c]));
      chk($sformatf("model_valid%0d", c), 32'(out_valid[c]), 32'(m_val[c]));
      chk($sformatf("model_err%0d", c), 32'(delay_err[c]), 32'(m_err[c]));
    end
  endtask

  task automatic step(input bit e, input logic [1:0] l, input logic [7:0] dl,
                      input logic [15:0] x);
    en = e; delay_ld = l; delay = dl; din = x;
    model_step(e, l, dl, x);
    @(posedge clk);
    #1;
    model_check();
  endtask

  typedef struct {
    bit         en;
    logic [1:0] ld;
    logic [3:0] d0;
    logic [7:0] n;
    logic [1:0] ev;
    logic [1:0] ee;
    logic [7:0] eo0;
    logic [7:0] eo1;
  } row_t;

  row_t rows[$];

  task automatic add(input bit e, input logic [1:0] l, input logic [3:0] d0,
                     input logic [7:0] n, input logic [1:0] ev, input logic [1:0] ee,
                     input logic [7:0] eo0, input logic [7:0] eo1);
    row_t r;
    r.en = e; r.ld = l; r.d0 = d0; r.n = n; r.ev = ev; r.ee = ee; r.eo0 = eo0; r.eo1 = eo1;
    rows.push_back(r);
  endtask

  initial begin
    // ch0 input = n, ch1 input = 0x80+n; outputs checked only where expected valid
    add(1, 2'b00, 0, 8'd1,  2'b00, 2'b00, 8'd0,  8'h00);
    add(1, 2'b00, 0, 8'd2,  2'b00, 2'b00, 8'd0,  8'h00);
    add(1, 2'b00, 0, 8'd3,  2'b11, 2'b00, 8'd1,  8'h81);
    add(1, 2'b00, 0, 8'd4,  2'b11, 2'b00, 8'd2,  8'h82);
    add(0, 2'b00, 0, 8'h55, 2'b11, 2'b00, 8'd2,  8'h82);
    add(0, 2'b00, 0, 8'h55, 2'b11, 2'b00, 8'd2,  8'h82);
    add(1, 2'b00, 0, 8'd5,  2'b11, 2'b00, 8'd3,  8'h83);
    add(1, 2'b00, 0, 8'd6,  2'b11, 2'b00, 8'd4,  8'h84);
    add(1, 2'b01, 5, 8'd7,  2'b10, 2'b00, 8'd0,  8'h85);
    add(1, 2'b00, 0, 8'd8,  2'b10, 2'b00, 8'd0,  8'h86);
    add(1, 2'b00, 0, 8'd9,  2'b10, 2'b00, 8'd0,  8'h87);
    add(1, 2'b00, 0, 8'd10, 2'b10, 2'b00, 8'd0,  8'h88);
    add(1, 2'b00, 0, 8'd11, 2'b10, 2'b00, 8'd0,  8'h89);
    add(1, 2'b00, 0, 8'd12, 2'b11, 2'b00, 8'd8,  8'h8A);
    add(1, 2'b00, 0, 8'd13, 2'b11, 2'b00, 8'd9,  8'h8B);
    add(1, 2'b01, 0, 8'd14, 2'b10, 2'b01, 8'd0,  8'h8C);
    add(1, 2'b00, 0, 8'd15, 2'b11, 2'b01, 8'd15, 8'h8D);
    add(1, 2'b01, 12, 8'd16, 2'b10, 2'b01, 8'd0, 8'h8E);
    for (int n = 17; n <= 23; n++)
      add(1, 2'b00, 0, 8'(n), 2'b10, 2'b01, 8'd0, 8'(8'h80 + n - 2));
    add(1, 2'b00, 0, 8'd24, 2'b11, 2'b01, 8'd17, 8'h96);
    add(1, 2'b01, 4, 8'd25, 2'b10, 2'b00, 8'd0,  8'h97);
    add(1, 2'b00, 0, 8'd26, 2'b10, 2'b00, 8'd0,  8'h98);
    add(1, 2'b00, 0, 8'd27, 2'b10, 2'b00, 8'd0,  8'h99);
    add(1, 2'b00, 0, 8'd28, 2'b10, 2'b00, 8'd0,  8'h9A);
    add(1, 2'b00, 0, 8'd29, 2'b11, 2'b00, 8'd26, 8'h9B);

    rst_n = 1'b0; en = 1'b0; delay_ld = '0; delay = '0; din = '0;
    #12;
    chk("reset_out", 32'(dout), 32'h0);
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_err", 32'(delay_err), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    foreach (rows[i]) begin
      row_t r;
      r = rows[i];
      step(r.en, r.ld, {4'd0, r.d0}, {8'h80 + r.n, r.n});
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(r.ev));
      chk($sformatf("tbl%0d_err", i), 32'(delay_err), 32'(r.ee));
      if (r.ev[0]) chk($sformatf("tbl%0d_out0", i), 32'(dout[7:0]), 32'(r.eo0));
      if (r.ev[1]) chk($sformatf("tbl%0d_out1", i), 32'(dout[15:8]), 32'(r.eo1));
    end

    // Maximum delay across several pointer wraps: out reads 7 accepted samples back
    step(1, 2'b01, 8'h08, 16'h0000);
    for (int i = 1; i <= 40; i++) begin
      step(1, 2'b00, 8'h00, {8'(i * 3), 8'(i)});
      if (i >= 8) begin
        chk($sformatf("maxd_out0_%0d", i), 32'(dout[7:0]), 32'(i - 7));
        chk($sformatf("maxd_valid0_%0d", i), 32'(out_valid[0]), 32'h1);
      end
    end

    for (int i = 0; i < 800; i++) begin
      logic [1:0] l;
      bit e;
      e = ($urandom_range(0, 3) != 0);
      l[0] = ($urandom_range(0, 15) == 0);
      l[1] = ($urandom_range(0, 15) == 0);
      step(e, l, 8'($urandom_range(0, 255)), 16'($urandom));
    end

    // Force a set error flag on ch1, then reset asynchronously between edges
    step(1, 2'b10, 8'h00, 16'h1234);
    chk("pre_reset_err1", 32'(delay_err[1]), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("async_out", 32'(dout), 32'h0);
    chk("async_valid", 32'(out_valid), 32'h0);
    chk("async_err", 32'(delay_err), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(1, 2'b00, 8'h00, {8'(8'h40 + i), 8'(i)});
      chk($sformatf("post_reset_valid_%0d", i), 32'(out_valid), (i >= 3) ? 32'h3 : 32'h0);
      if (i >= 3) chk($sformatf("post_reset_out_%0d", i), 32'(dout),
                      32'({8'(8'h40 + i - 2), 8'(i - 2)}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
